// File: rtl/grid_display.sv
// Row-scanning 8x8 LED matrix driver: serial column shift, latch, one-hot row.
// Define GRID_DISPLAY_BLANK_EN to blank row_sel during shift and latch.
module grid_display #(
  parameter int SCLK_DIV = 2,
  parameter int DWELL    = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] grid_in,
  input  logic        grid_load,
  output logic        sclk,
  output logic        sdata,
  output logic        slatch,
  output logic [7:0]  row_sel,
  output logic        frame_done
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_LATCH,
    ST_DWELL
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      row_q, row_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sclk_d;
  logic            slatch_d;
  logic [7:0]      row_sel_d;
  logic            fd_d;

  logic [63:0]     shadow_q;
  logic [63:0]     active_q;
  logic            pending_q;
  logic [63:0]     src;
  logic            boundary;
  logic            swap;
  logic            div_end;
  logic            dwell_end;
  logic            dwell_near;
  logic [7:0]      onehot;

  assign div_end    = div_q == DW'(SCLK_DIV - 1);
  assign dwell_end  = cnt_q == CW'(DWELL - 1);
  assign dwell_near = (DWELL > 1) && (cnt_q == CW'(DWELL - 2));
  assign onehot     = 8'd1 << row_q;

  assign boundary = (state_q == ST_SHIFT) && (row_q == 3'd0) &&
                    (bit_q == 3'd7) && (div_q == '0) && !sclk;
  assign swap     = boundary && pending_q;

  // The swap cycle already drives bit 7 of the incoming generation.
  assign src   = swap ? shadow_q : active_q;
  assign sdata = (state_q == ST_SHIFT) && src[{row_q, bit_q}];

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    row_d     = row_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk;
    slatch_d  = 1'b0;
    row_sel_d = row_sel;
    fd_d      = 1'b0;
    unique case (1'b1)
      (state_q == ST_SHIFT): begin
        if (!div_end) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
              state_d  = ST_LATCH;
              slatch_d = 1'b1;
`ifdef GRID_DISPLAY_BLANK_EN
              row_sel_d = 8'h00;
`else
              row_sel_d = onehot;
`endif
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end
      end
      (state_q == ST_LATCH): begin
        state_d = ST_DWELL;
        cnt_d   = '0;
        fd_d    = (DWELL == 1) && (row_q == 3'd7);
`ifdef GRID_DISPLAY_BLANK_EN
        row_sel_d = onehot;
`endif
      end
      (state_q == ST_DWELL): begin
        if (dwell_end) begin
          state_d = ST_SHIFT;
          bit_d   = 3'd7;
          row_d   = row_q + 3'd1;
`ifdef GRID_DISPLAY_BLANK_EN
          row_sel_d = 8'h00;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
          fd_d  = dwell_near && (row_q == 3'd7);
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SHIFT;
      bit_q      <= 3'd7;
      row_q      <= 3'd0;
      div_q      <= '0;
      cnt_q      <= '0;
      sclk       <= 1'b0;
      slatch     <= 1'b0;
      row_sel    <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      row_q      <= row_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sclk       <= sclk_d;
      slatch     <= slatch_d;
      row_sel    <= row_sel_d;
      frame_done <= fd_d;
    end
  end

  // A load on the swap cycle is captured and stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (grid_load) shadow_q <= grid_in;
      if (swap) active_q <= shadow_q;
      pending_q <= grid_load | (pending_q & ~swap);
    end
  end

endmodule

// File: tb/tb_grid_display.sv
// Scoreboard bench for grid_display: expected rows queued per frame,
// monitor pops on every slatch and checks shifted data and row_sel.
module tb_grid_display;

  localparam int SD  = 2;
  localparam int DW  = 4;
  localparam int ROW = 16 * SD + 1 + DW;
  localparam int FRM = 8 * ROW;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] grid_in;
  logic        grid_load;
  logic        sclk;
  logic        sdata;
  logic        slatch;
  logic [7:0]  row_sel;
  logic        frame_done;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int rel_cyc = 0;
  int last_fd = -1;

  logic [15:0] exp_q[$];
  logic [15:0] e;
  logic        prev_sclk = 1'b0;
  logic [7:0]  word = 8'h00;
  int          nbits = 0;
  logic        hold_v = 1'b0;
  logic [23:0] hold_d = '0;

  grid_display #(
    .SCLK_DIV(SD),
    .DWELL(DW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .grid_in(grid_in),
    .grid_load(grid_load),
    .sclk(sclk),
    .sdata(sdata),
    .slatch(slatch),
    .row_sel(row_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  task automatic push_frame(input logic [63:0] g);
    for (int r = 0; r < 8; r++)
      exp_q.push_back({8'(1 << r), g[8*r +: 8]});
  endtask

  task automatic load(input logic [63:0] v);
    grid_in   = v;
    grid_load = 1'b1;
    @(negedge clk);
    grid_load = 1'b0;
  endtask

  task automatic wait_fd();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * FRM && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got none, expected pulse");
    end
  endtask

  task automatic wait_latch();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * ROW && !seen; i++) begin
      @(negedge clk);
      if (slatch) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL slatch_timeout: got none, expected pulse");
    end
  endtask

  // Rebuild each row from sdata sampled at sclk rising edges.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_sclk = 1'b0;
      nbits     = 0;
      word      = 8'h00;
      hold_v    = 1'b0;
    end else begin
`ifdef GRID_DISPLAY_BLANK_EN
      if (hold_v) begin
        chk("latch_row", {row_sel, hold_d}, {hold_d[23:16], hold_d});
        hold_v = 1'b0;
      end
      if (sclk) chk("blank_shift", row_sel, 8'h00);
`endif
      if (sclk && !prev_sclk) begin
        word = {word[6:0], sdata};
        nbits++;
      end
      prev_sclk = sclk;
      if (slatch) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_latch: got row_sel %h, expected none",
                   row_sel);
        end else begin
          e = exp_q.pop_front();
`ifdef GRID_DISPLAY_BLANK_EN
          chk("blank_latch", row_sel, 8'h00);
          chk("latch_data", {word, 8'(nbits)}, {e[7:0], 8'd8});
          hold_d = {e[15:8], word, 8'(nbits)};
          hold_v = 1'b1;
`else
          chk("latch", {row_sel, word, 8'(nbits)}, {e, 8'd8});
`endif
        end
        nbits = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      last_fd = -1;
    end else if (frame_done) begin
      if (last_fd < 0) chk("first_frame_done", cyc - rel_cyc, FRM - 1);
      else chk("frame_period", cyc - last_fd, FRM);
      last_fd = cyc;
    end
  end

  initial begin
    reset_n   = 1'b0;
    grid_in   = '0;
    grid_load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {sclk, sdata, slatch, row_sel, frame_done}, 0);
    @(negedge clk);
    push_frame(64'h0);
    #2;
    reset_n = 1'b1;
    rel_cyc = cyc;

    wait_latch();
    chk("first_slatch", cyc - rel_cyc, 16 * SD);
    load(64'h0000_0000_0000_00A5);
    wait_fd();
    @(negedge clk);

    push_frame(64'h0000_0000_0000_00A5);
    repeat (40) @(negedge clk);
    load(64'h8000_0000_0000_0001);
    wait_fd();
    @(negedge clk);

    push_frame(64'h8000_0000_0000_0001);
    repeat (20) @(negedge clk);
    load(64'h1234_5678_9ABC_DEF0);
    repeat (150) @(negedge clk);
    load(64'h00FF_0000_0000_FF00);
    wait_fd();
    @(negedge clk);

    push_frame(64'h00FF_0000_0000_FF00);
    repeat (30) @(negedge clk);
    load(64'h0102_0408_1020_4080);
    wait_fd();
    @(negedge clk);

    push_frame(64'h0102_0408_1020_4080);
    load(64'hC3C3_0000_0000_3C3C);
    wait_fd();
    @(negedge clk);

    push_frame(64'hC3C3_0000_0000_3C3C);
    wait_fd();
    @(negedge clk);

    push_frame(64'hC3C3_0000_0000_3C3C);
    repeat (3) wait_latch();
    repeat (8) @(negedge clk);
`ifdef GRID_DISPLAY_BLANK_EN
    chk("pre_reset_row", row_sel, 8'h00);
`else
    chk("pre_reset_row", row_sel, 8'h04);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {sclk, sdata, slatch, row_sel, frame_done}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_frame(64'h0);
    #2;
    reset_n = 1'b1;
    rel_cyc = cyc;
    wait_fd();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
